data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Data-memory target answering the load/store traffic the core datapath emits (DataAddr/WriteData out, ReadData in).
//  Accepts one request per valid/ready handshake, models wait states, performs byte/half/word access with lane select,
//  returns sign/zero-extended load data with a one-cycle response pulse. Sits between core and data storage.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; power of two
//  ADDR_W   16   byte-address width (matches core DataAddr)
//  LATENCY  2    wait cycles between acceptance and response (0..15)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept (high only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word; 11 treated as word
//  req_unsigned in   1   loads: 1 zero-extend, 0 sign-extend
//  req_addr     in   16  byte address
//  req_wdata    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid    out  1   one-cycle pulse: request completed
//  rsp_rdata    out  32  load result; 0 for stores
//  rsp_err      out  1   misaligned access flag (0 when macro absent)
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, request regs=0.
//   Memory array contents unaffected by reset.
//  Handshake: accept when req_valid & req_ready at rising edge; latch we/size/unsigned/addr/wdata. Inputs ignored otherwise.
//  FSM: IDLE -accept-> (LATENCY==0 ? ACCESS : WAIT); WAIT counts LATENCY-1..0, then ACCESS; ACCESS -> RESP; RESP -> IDLE.
//   ACCESS: store commits to array / load data captured into rsp_rdata. RESP: rsp_valid=1 for exactly one cycle.
//  Latency: accept at edge N -> rsp_valid high in cycle N+LATENCY+2. req_ready low from N+1 until back in IDLE.
//  Back-to-back: next request accepted in cycle after RESP; no overlap, no pipelining.
//  Word index = addr[ADDR_W-1:2] modulo DEPTH (upper bits wrap, no error). Lane = addr[1:0].
//  Stores: byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all; untouched lanes keep value.
//  Loads: select lane(s) same way, right-align, extend bit 7/15 per req_unsigned; word returns full word.
//  rsp_rdata holds last value until next ACCESS; stores set rsp_rdata=0.
//  Reset mid-operation: FSM to IDLE immediately, pending request dropped; a store already past ACCESS stays committed,
//   a store not yet in ACCESS never writes.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned -> no array write,
//   rsp_rdata=0, rsp_err=1 pulsed together with rsp_valid; same latency as normal access.
//  MISALIGN_TRAP_EN undefined: offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]);
//   rsp_err tied 0.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0; release, idle 5 cycles -> no rsp_valid.
//  2 Word store 0xDEADBEEF @0x0010 then word load @0x0010, LATENCY=2 -> each rsp_valid exactly 4 cycles after accept;
//    load rsp_rdata=0xDEADBEEF.
//  3 Byte store 0x80 @0x0013 onto 0x00000000; lb @0x0013 -> 0xFFFFFF80; lbu -> 0x00000080; lw @0x0010 -> 0x80000000.
//  4 Half store 0xBEEF @0x0022 onto 0x11223344; lh @0x0022 -> 0xFFFFBEEF; lw @0x0020 -> 0xBEEF3344.
//  5 Hold req_valid=1 continuously with 3 queued requests -> accepted only when req_ready=1; req_ready low during
//    WAIT/ACCESS/RESP; addr 0x0400 (DEPTH=256) aliases word 0.
//  6 lw @0x0012: with MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0, memory unchanged for sw; without -> reads word 0x0010,
//    rsp_err=0. Also assert reset mid-WAIT of a store -> target word unchanged, req_ready=1 after reset release.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory target: one valid/ready request at a time, LATENCY wait states, byte/half/word lanes.
// Optional build macro MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IDX_W    = $clog2(DEPTH);
   localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t             r_state, w_state_nxt;
   logic [3:0]         r_cnt, w_cnt_nxt;
   logic               w_accept;

   logic               r_we;
   logic [1:0]         r_size;
   logic               r_unsigned;
   logic [IDX_W+1:0]   r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_rdata;
   logic               r_err;

   logic [31:0]        r_mem [DEPTH];

   logic [IDX_W-1:0]   w_idx;
   logic [1:0]         w_lane;
   logic [3:0]         w_mask;
   logic [31:0]        w_wdata_ln;
   logic               w_trap;
   logic [31:0]        w_word;
   logic [31:0]        w_shifted;
   logic [31:0]        w_load;
   logic               w_mem_we;
   logic               w_unused_addr_hi;

   // Address bits above the word index wrap silently.
   assign w_unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept = 1'b1;
               if (LATENCY == 0) begin
                  w_state_nxt = S_ACCESS;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = LAT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) w_state_nxt = S_ACCESS;
            else             w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP: begin
            rsp_valid   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Lane decode: without the trap, misaligned low bits are simply forced to zero.
   always_comb begin
      w_trap     = 1'b0;
      w_lane     = r_addr[1:0];
      w_mask     = '0;
      w_wdata_ln = '0;
      case (r_size)
         2'b00: begin
            w_mask     = 4'b0001 << w_lane;
            w_wdata_ln = {4{r_wdata[7:0]}};
         end
         2'b01: begin
`ifdef MISALIGN_TRAP_EN
            w_trap     = r_addr[0];
`endif
            w_lane     = {r_addr[1], 1'b0};
            w_mask     = 4'b0011 << w_lane;
            w_wdata_ln = {2{r_wdata[15:0]}};
         end
         default: begin
`ifdef MISALIGN_TRAP_EN
            w_trap     = |r_addr[1:0];
`endif
            w_lane     = 2'b00;
            w_mask     = 4'b1111;
            w_wdata_ln = r_wdata;
         end
      endcase
   end

   assign w_idx     = r_addr[IDX_W+1:2];
   assign w_word    = r_mem[w_idx];
   assign w_shifted = w_word >> {w_lane, 3'b000};
   assign w_mem_we  = (r_state == S_ACCESS) && r_we && !w_trap;

   always_comb begin
      w_load = w_word;
      case (r_size)
         2'b00:   w_load = r_unsigned ? {24'h0, w_shifted[7:0]}
                                      : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_load = r_unsigned ? {16'h0, w_shifted[15:0]}
                                      : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load = w_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_ln[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we       <= 1'b0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[IDX_W+1:0];
            r_wdata    <= req_wdata;
         end
         if (r_state == S_ACCESS) begin
            r_rdata <= (r_we || w_trap) ? '0 : w_load;
            r_err   <= w_trap;
         end
      end
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err && (r_state == S_RESP);

endmodule
